// File: rtl/fir_mac_serial.sv
// Serial FIR filter: a single multiplier and accumulator step through every tap of each accepted
// sample. Coefficients are writable at run time; rounding and saturation are chosen by parameter.
//
// state | meaning
// IDLE  | in_ready high, waiting for a sample; coefficient writes accepted
// MAC   | one tap product accumulated per cycle, idx 0..TAPS-1
// OUT   | quantised result held on fir_out until out_ready
module fir_mac_serial #(
  parameter int DW        = 9,
  parameter int CW        = 16,
  parameter int TAPS      = 21,
  parameter int OUT_SHIFT = 16,
  parameter int RND       = 0,
  parameter int SAT       = 0,
  localparam int AIW      = $clog2(TAPS)
) (
  input  logic                 clk_100k,
  input  logic                 rst,
  input  logic signed [DW-1:0] samp_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 coef_we,
  input  logic [AIW-1:0]       coef_addr,
  input  logic signed [CW-1:0] coef_data,
  output logic signed [DW-1:0] fir_out,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int PW = DW + CW;
  localparam int AW = DW + CW + $clog2(TAPS);
  // One extra bit so the rounding constant can never wrap the final sum.
  localparam int QW = AW + 1;

  localparam logic [AIW-1:0]       LAST_IDX = AIW'(TAPS - 1);
  localparam logic signed [QW-1:0] RND_K    = (RND != 0) ? (QW'(1) << (OUT_SHIFT - 1)) : '0;
  localparam logic signed [QW-1:0] SAT_MAX  = QW'((2 ** (DW - 1)) - 1);
  localparam logic signed [QW-1:0] SAT_MIN  = -SAT_MAX - QW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t               r_state;
  logic signed [DW-1:0] r_samp [TAPS];
  logic signed [CW-1:0] r_coef [TAPS];
  logic signed [AW-1:0] r_acc;
  logic [AIW-1:0]       r_idx;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic signed [DW-1:0] r_fir_out;

  logic signed [PW-1:0] w_prod;
  logic signed [AW-1:0] w_sum;
  logic signed [QW-1:0] w_rnd;
  logic signed [QW-1:0] w_shift;
  logic                 w_above;
  logic                 w_below;
  logic signed [DW-1:0] w_q;
  logic                 w_coef_wr;
  logic                 w_accept;

  assign w_prod  = PW'(r_samp[r_idx]) * PW'(r_coef[r_idx]);
  assign w_sum   = r_acc + AW'(w_prod);
  assign w_rnd   = QW'(w_sum) + RND_K;
  assign w_shift = w_rnd >>> OUT_SHIFT;
  assign w_above = (w_shift > SAT_MAX);
  assign w_below = (w_shift < SAT_MIN);

  always_comb begin
    w_q = w_shift[DW-1:0];
    if (SAT != 0) begin
      if (w_above) begin
        w_q = SAT_MAX[DW-1:0];
      end else if (w_below) begin
        w_q = SAT_MIN[DW-1:0];
      end
    end
  end

  // Out-of-range addresses are dropped rather than aliased onto a real tap.
  assign w_coef_wr = coef_we && (r_state == S_IDLE) && (32'(coef_addr) < TAPS);
  assign w_accept  = in_valid && r_in_ready && (r_state == S_IDLE);

  always_ff @(posedge clk_100k or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        r_samp[k] <= '0;
        r_coef[k] <= '0;
      end
      r_acc       <= '0;
      r_idx       <= '0;
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_fir_out   <= '0;
    end else begin
      if (w_coef_wr) begin
        r_coef[coef_addr] <= coef_data;
      end
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            for (int k = TAPS - 1; k > 0; k--) begin
              r_samp[k] <= r_samp[k-1];
            end
            r_samp[0]  <= samp_in;
            r_acc      <= '0;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= w_sum;
          if (r_idx == LAST_IDX) begin
            // Park idx at 0 so the delay-line read never leaves the array.
            r_idx       <= '0;
            r_fir_out   <= w_q;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end else begin
            r_idx <= r_idx + AIW'(1);
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign fir_out   = r_fir_out;

endmodule

// File: tb/tb_fir_mac_serial.sv
// Bench for fir_mac_serial: three instances (wrap, saturate, round) share stimulus and are
// compared against a convolution model of the delay line and coefficient bank.
module tb_fir_mac_serial;
  localparam int DW   = 9;
  localparam int CW   = 16;
  localparam int TAPS = 21;
  localparam int AIW  = 5;

  logic                 clk;
  logic                 rst;
  logic signed [DW-1:0] samp_in;
  logic                 in_valid;
  logic                 coef_we;
  logic [AIW-1:0]       coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 out_ready;

  logic                 in_ready_w, in_ready_s, in_ready_r;
  logic                 out_valid_w, out_valid_s, out_valid_r;
  logic signed [DW-1:0] fir_out_w, fir_out_s, fir_out_r;

  int checks;
  int failures;

  int m_coef [TAPS];
  int m_samp [TAPS];

  fir_mac_serial u_wrap (
    .clk_100k(clk), .rst(rst), .samp_in(samp_in), .in_valid(in_valid), .in_ready(in_ready_w),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .fir_out(fir_out_w), .out_valid(out_valid_w), .out_ready(out_ready)
  );

  fir_mac_serial #(.SAT(1)) u_sat (
    .clk_100k(clk), .rst(rst), .samp_in(samp_in), .in_valid(in_valid), .in_ready(in_ready_s),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .fir_out(fir_out_s), .out_valid(out_valid_s), .out_ready(out_ready)
  );

  fir_mac_serial #(.RND(1)) u_rnd (
    .clk_100k(clk), .rst(rst), .samp_in(samp_in), .in_valid(in_valid), .in_ready(in_ready_r),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .fir_out(fir_out_r), .out_valid(out_valid_r), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic longint m_sum();
    longint s = 0;
    for (int k = 0; k < TAPS; k++) s += longint'(m_samp[k]) * longint'(m_coef[k]);
    return s;
  endfunction

  function automatic int m_quant(longint s, bit rnd, bit sat);
    longint t;
    t = (s + (rnd ? 64'sd32768 : 64'sd0)) >>> 16;
    if (sat) begin
      if (t > 255) t = 255;
      if (t < -256) t = -256;
    end else begin
      t = t & 64'sd511;
      if (t >= 256) t = t - 512;
    end
    return int'(t);
  endfunction

  task automatic m_push(int s);
    for (int k = TAPS - 1; k > 0; k--) m_samp[k] = m_samp[k-1];
    m_samp[0] = s;
  endtask

  task automatic m_clear();
    for (int k = 0; k < TAPS; k++) begin
      m_samp[k] = 0;
      m_coef[k] = 0;
    end
  endtask

  function automatic int rand_samp();
    return int'($urandom_range(0, 511)) - 256;
  endfunction

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    coef_we = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid_w !== 1'b0 || out_valid_s !== 1'b0 || out_valid_r !== 1'b0 ||
        fir_out_w !== 9'sd0 || fir_out_s !== 9'sd0 || fir_out_r !== 9'sd0 ||
        in_ready_w !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: got out_valid=%b fir_out=%0d in_ready=%b expected 0 0 0",
               out_valid_w, fir_out_w, in_ready_w);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_clear();
  endtask

  task automatic set_coef(int addr, int val);
    logic signed [15:0] v16;
    v16 = val[15:0];
    @(negedge clk);
    coef_we = 1'b1;
    coef_addr = addr[4:0];
    coef_data = v16;
    @(posedge clk);
    #1;
    coef_we = 1'b0;
    if (addr < TAPS) m_coef[addr] = int'(v16);
  endtask

  task automatic accept(int s, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready_w && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_w) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
      ok = 1'b0;
      return;
    end
    samp_in = 9'(s);
    in_valid = 1'b1;
    @(posedge clk);
    m_push(s);
    #1;
    in_valid = 1'b0;
    ok = 1'b1;
  endtask

  task automatic run_sample(int s, int hold, bit poke, output int got_w, output int got_s,
                            output int got_r);
    bit ok;
    bit busy;
    int cyc, e_w, e_s, e_r, held;
    logic [15:0] c0;
    got_w = -9999; got_s = -9999; got_r = -9999;
    accept(s, ok);
    if (!ok) return;
    e_w = m_quant(m_sum(), 0, 0);
    e_s = m_quant(m_sum(), 0, 1);
    e_r = m_quant(m_sum(), 1, 0);
    cyc = 0;
    busy = 0;
    while (!out_valid_w && cyc < TAPS + 10) begin
      @(posedge clk);
      #1;
      cyc++;
      if (poke && cyc == 3) begin
        c0 = m_coef[0][15:0];
        coef_we = 1'b1;
        coef_addr = '0;
        coef_data = ~c0;
        in_valid = 1'b1;
        samp_in = 9'(rand_samp());
      end
      if (cyc == 4) begin
        coef_we = 1'b0;
        in_valid = 1'b0;
      end
      if (in_ready_w) busy = 1;
    end
    coef_we = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (cyc !== TAPS) begin
      failures++;
      $display("FAIL latency: got %0d cycles expected %0d", cyc, TAPS);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL in_ready_busy: got in_ready=1 during MAC expected 0");
    end
    got_w = fir_out_w;
    got_s = fir_out_s;
    got_r = fir_out_r;
    checks++;
    if (out_valid_s !== 1'b1 || out_valid_r !== 1'b1) begin
      failures++;
      $display("FAIL out_valid_all: got sat=%b rnd=%b expected 1 1", out_valid_s, out_valid_r);
    end
    checks++;
    if (got_w !== e_w) begin
      failures++;
      $display("FAIL out_wrap: got %0d expected %0d", got_w, e_w);
    end
    checks++;
    if (got_s !== e_s) begin
      failures++;
      $display("FAIL out_sat: got %0d expected %0d", got_s, e_s);
    end
    checks++;
    if (got_r !== e_r) begin
      failures++;
      $display("FAIL out_rnd: got %0d expected %0d", got_r, e_r);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      held = fir_out_w;
      checks++;
      if (out_valid_w !== 1'b1 || in_ready_w !== 1'b0 || held !== e_w) begin
        failures++;
        $display("FAIL backpressure_hold: got valid=%b ready=%b out=%0d expected 1 0 %0d",
                 out_valid_w, in_ready_w, held, e_w);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid_w !== 1'b0 || in_ready_w !== 1'b1) begin
      failures++;
      $display("FAIL drain: got valid=%b ready=%b expected 0 1", out_valid_w, in_ready_w);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (in_ready_w !== 1'b0 || out_valid_w !== 1'b0 || fir_out_w !== 9'sd0 ||
        out_valid_s !== 1'b0 || out_valid_r !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got ready=%b valid=%b out=%0d expected 0 0 0",
               in_ready_w, out_valid_w, fir_out_w);
    end
    rst = 1'b0;
    m_clear();
    #1;
    checks++;
    if (in_ready_w !== 1'b0) begin
      failures++;
      $display("FAIL ready_before_edge: got %b expected 0", in_ready_w);
    end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready_w !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_release: got %b expected 1", in_ready_w);
    end
  endtask

  task automatic test_single_tap();
    int gw, gs, gr;
    do_reset();
    set_coef(0, 16'h4000);
    run_sample(100, 0, 0, gw, gs, gr);
    checks++;
    if (gw !== 25 || gs !== 25 || gr !== 25) begin
      failures++;
      $display("FAIL single_tap: got %0d/%0d/%0d expected 25", gw, gs, gr);
    end
  endtask

  task automatic test_impulse();
    int gw, gs, gr;
    do_reset();
    for (int k = 0; k < TAPS; k++) set_coef(k, 1024 * k);
    for (int i = 0; i <= TAPS; i++) begin
      run_sample((i == 0) ? 64 : 0, 0, 0, gw, gs, gr);
      checks++;
      if (gw !== ((i < TAPS) ? i : 0)) begin
        failures++;
        $display("FAIL impulse_%0d: got %0d expected %0d", i, gw, (i < TAPS) ? i : 0);
      end
    end
  endtask

  task automatic test_overflow();
    int gw, gs, gr;
    do_reset();
    for (int k = 0; k < TAPS; k++) set_coef(k, 16'h7FFF);
    for (int i = 0; i < TAPS; i++) run_sample(255, 0, 0, gw, gs, gr);
    checks++;
    if (gs !== 255 || gw !== 117) begin
      failures++;
      $display("FAIL overflow_pos: got sat=%0d wrap=%0d expected 255 117", gs, gw);
    end
    for (int i = 0; i < TAPS; i++) run_sample(-256, 0, 0, gw, gs, gr);
    checks++;
    if (gs !== -256 || gw !== -128) begin
      failures++;
      $display("FAIL overflow_neg: got sat=%0d wrap=%0d expected -256 -128", gs, gw);
    end
  endtask

  task automatic test_rounding();
    int gw, gs, gr;
    do_reset();
    set_coef(0, 16'h8000);
    run_sample(1, 0, 0, gw, gs, gr);
    checks++;
    if (gw !== -1 || gr !== 0) begin
      failures++;
      $display("FAIL rounding: got trunc=%0d rnd=%0d expected -1 0", gw, gr);
    end
  endtask

  task automatic test_backpressure();
    int gw, gs, gr;
    do_reset();
    for (int k = 0; k < TAPS; k++) set_coef(k, int'($urandom_range(0, 65535)));
    set_coef(TAPS + 3, 16'h1234);
    run_sample(rand_samp(), 10, 1, gw, gs, gr);
    run_sample(rand_samp(), 0, 0, gw, gs, gr);
    run_sample(rand_samp(), 2, 1, gw, gs, gr);
    run_sample(rand_samp(), 0, 0, gw, gs, gr);
  endtask

  task automatic test_random();
    int gw, gs, gr;
    do_reset();
    for (int k = 0; k < TAPS; k++) set_coef(k, int'($urandom_range(0, 65535)));
    for (int i = 0; i < 10; i++) begin
      if (i == 5) set_coef(int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 65535)));
      run_sample(rand_samp(), int'($urandom_range(0, 3)), 0, gw, gs, gr);
    end
  endtask

  task automatic test_back_to_back();
    int q_w[$], q_s[$], q_r[$];
    int cyc, last, n_in, n_out, s, gw, gs, gr;
    do_reset();
    for (int k = 0; k < TAPS; k++) set_coef(k, int'($urandom_range(0, 65535)));
    s = rand_samp();
    samp_in = 9'(s);
    in_valid = 1'b1;
    out_ready = 1'b1;
    last = -1; n_in = 0; n_out = 0; cyc = 0;
    while (n_out < 5 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (out_valid_w) begin
        checks++;
        if (q_w.size() == 0) begin
          failures++;
          $display("FAIL b2b_spurious: got out_valid=1 expected 0");
        end else begin
          gw = q_w.pop_front(); gs = q_s.pop_front(); gr = q_r.pop_front();
          if (fir_out_w !== gw || fir_out_s !== gs || fir_out_r !== gr) begin
            failures++;
            $display("FAIL b2b_out: got %0d/%0d/%0d expected %0d/%0d/%0d",
                     fir_out_w, fir_out_s, fir_out_r, gw, gs, gr);
          end
        end
        n_out++;
      end
      if (in_ready_w && n_in < 5) begin
        if (last >= 0) begin
          checks++;
          if (cyc - last !== TAPS + 2) begin
            failures++;
            $display("FAIL b2b_period: got %0d expected %0d", cyc - last, TAPS + 2);
          end
        end
        last = cyc;
        m_push(s);
        q_w.push_back(m_quant(m_sum(), 0, 0));
        q_s.push_back(m_quant(m_sum(), 0, 1));
        q_r.push_back(m_quant(m_sum(), 1, 0));
        n_in++;
        @(posedge clk);
        #1;
        s = rand_samp();
        samp_in = 9'(s);
        if (n_in == 5) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (n_out !== 5) begin
      failures++;
      $display("FAIL b2b_timeout: got %0d outputs expected 5", n_out);
    end
  endtask

  task automatic test_reset_mid();
    int gw, gs, gr, n;
    bit ok;
    do_reset();
    set_coef(0, 16'h4000);
    run_sample(100, 0, 0, gw, gs, gr);
    accept(77, ok);
    repeat (7) @(posedge clk);
    do_reset();
    set_coef(0, 16'h4000);
    accept(100, ok);
    n = 0;
    while (!out_valid_w && n < TAPS + 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (out_valid_w !== 1'b1) begin
      failures++;
      $display("FAIL out_wait_timeout: got out_valid=0 expected 1");
    end
    do_reset();
    run_sample(55, 0, 0, gw, gs, gr);
    checks++;
    if (gw !== 0) begin
      failures++;
      $display("FAIL zero_coef_after_reset: got %0d expected 0", gw);
    end
    for (int k = 0; k < TAPS; k++) set_coef(k, int'($urandom_range(0, 65535)));
    for (int i = 0; i < 3; i++) run_sample(rand_samp(), 0, 0, gw, gs, gr);
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    samp_in = '0;
    in_valid = 1'b0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    out_ready = 1'b0;
    checks = 0;
    failures = 0;
    m_clear();
    test_reset();
    test_single_tap();
    test_impulse();
    test_overflow();
    test_rounding();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
